// File: rtl/inst_sram_rsp_pkg.sv
// ============================================================================
// Module   : inst_sram_rsp_pkg
// Brief    : Shared types and constants for the instruction SRAM responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package inst_sram_rsp_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h8000_0000;

    // Pin levels while the SRAM is not being read
    localparam logic       SRAM_CE_N_OFF = 1'b1;
    localparam logic       SRAM_OE_N_OFF = 1'b1;
    localparam logic       SRAM_WE_N_OFF = 1'b1;
    localparam logic [3:0] SRAM_BE_N_OFF = 4'hF;

endpackage : inst_sram_rsp_pkg

`default_nettype wire

// File: rtl/inst_sram_rsp.sv
// ============================================================================
// Module   : inst_sram_rsp
// Brief    : Instruction-fetch responder driving a read-only base SRAM port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_sram_rsp
    import inst_sram_rsp_pkg::*;
#(
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int          SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_i,
    input  logic [31:0]        pc_i,
    input  logic               branch_flag_i,
    output logic [31:0]        inst_o,
    output logic [31:0]        inst_pc_o,
    output logic               inst_valid_o,
    output logic               addr_err_o,
    output logic               stall_req_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic [3:0]         sram_be_n_o,
    input  logic [31:0]        sram_data_i
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic               err_pend_q, err_pend_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        inst_pc_q, inst_pc_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic [3:0]         be_n_q, be_n_d;

    logic [32:0] diff;
    logic [31:0] above_window;
    logic        legal;
    logic        accept;
    logic        cmpl_strobe;

    // Bit 32 of the widened difference is the borrow: pc below the window
    assign diff         = {1'b0, pc_i} - {1'b0, ADDR_BASE};
    assign above_window = diff[31:0] >> (SRAM_AW + 2);
    assign legal        = !diff[32] && (above_window == 32'h0) && (pc_i[1:0] == 2'b00);
    assign accept       = ce_i && ((state_q == IDLE) || (cnt_q == 3'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        err_pend_d  = err_pend_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        addr_d      = addr_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        be_n_d      = be_n_q;
        cmpl_strobe = 1'b0;

        if (state_q == ACCESS) begin
            if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
                if (branch_flag_i) begin
                    drop_d = 1'b1;
                end
            end else begin
                if (!drop_q && !branch_flag_i) begin
                    cmpl_strobe = 1'b1;
                    valid_d     = 1'b1;
                    err_d       = err_pend_q;
                    inst_d      = err_pend_q ? NOP : sram_data_i;
                    inst_pc_d   = pc_q;
                end
                state_d    = IDLE;
                err_pend_d = 1'b0;
                ce_n_d     = SRAM_CE_N_OFF;
                oe_n_d     = SRAM_OE_N_OFF;
                be_n_d     = SRAM_BE_N_OFF;
            end
        end

        if (accept) begin
            drop_d = 1'b0;
            pc_d   = pc_i;
            if (legal) begin
                state_d    = ACCESS;
                cnt_d      = WAIT_INIT;
                err_pend_d = 1'b0;
                addr_d     = diff[SRAM_AW+1:2];
                ce_n_d     = 1'b0;
                oe_n_d     = 1'b0;
                be_n_d     = 4'h0;
            end else if (cmpl_strobe) begin
                // Strobe slot is taken by the completing fetch: report the
                // error one cycle later through a pin-less zero-wait access.
                state_d    = ACCESS;
                cnt_d      = 3'd0;
                err_pend_d = 1'b1;
            end else begin
                valid_d   = 1'b1;
                err_d     = 1'b1;
                inst_d    = NOP;
                inst_pc_d = pc_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 3'd0;
            drop_q     <= 1'b0;
            err_pend_q <= 1'b0;
            pc_q       <= 32'h0;
            inst_q     <= NOP;
            inst_pc_q  <= 32'h0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            ce_n_q     <= SRAM_CE_N_OFF;
            oe_n_q     <= SRAM_OE_N_OFF;
            be_n_q     <= SRAM_BE_N_OFF;
        end else begin
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            err_pend_q <= err_pend_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            be_n_q     <= be_n_d;
        end
    end

    assign stall_req_o  = (state_q == ACCESS) && (cnt_q != 3'd0);
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = valid_q;
    assign addr_err_o   = err_q;
    assign sram_addr_o  = addr_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = SRAM_WE_N_OFF;
    assign sram_be_n_o  = be_n_q;

endmodule : inst_sram_rsp

`default_nettype wire

// File: tb/tb_inst_sram_rsp.sv
// ============================================================================
// Module   : tb_inst_sram_rsp
// Brief    : Scoreboard bench for inst_sram_rsp at WAIT_STATES 0, 1 and 2.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_sram_rsp;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        br = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_data = 32'h0;
    logic        mon_en = 1'b0;
    int          sel = 1;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];

    logic [31:0] inst_a [3];
    logic [31:0] ipc_a [3];
    logic [31:0] sdata_a [3];
    logic        valid_a [3];
    logic        err_a [3];
    logic        stall_a [3];
    logic        ce_n_a [3];
    logic        oe_n_a [3];
    logic        we_n_a [3];
    logic [19:0] addr_a [3];
    logic [3:0]  be_n_a [3];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [19:0] a);
        return {12'hC0D, a};
    endfunction

    function automatic exp_t exp_of(input logic [31:0] p);
        logic [31:0] off;
        off = (p - BASE) >> 2;
        return '{inst: mem_fn(off[19:0]), pc: p, err: 1'b0};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign sdata_a[g] = fixed_en ? fixed_data : mem_fn(addr_a[g]);
        inst_sram_rsp #(
            .WAIT_STATES (g),
            .ADDR_BASE   (BASE),
            .SRAM_AW     (20)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .ce_i          (ce),
            .pc_i          (pc),
            .branch_flag_i (br),
            .inst_o        (inst_a[g]),
            .inst_pc_o     (ipc_a[g]),
            .inst_valid_o  (valid_a[g]),
            .addr_err_o    (err_a[g]),
            .stall_req_o   (stall_a[g]),
            .sram_addr_o   (addr_a[g]),
            .sram_ce_n_o   (ce_n_a[g]),
            .sram_oe_n_o   (oe_n_a[g]),
            .sram_we_n_o   (we_n_a[g]),
            .sram_be_n_o   (be_n_a[g]),
            .sram_data_i   (sdata_a[g])
        );
    end

    // Every strobe of the selected instance must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en && valid_a[sel]) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: strobe inst=%h pc=%h err=%b, required no strobe",
                         inst_a[sel], ipc_a[sel], err_a[sel]);
            end else begin
                e = sb.pop_front();
                if (inst_a[sel] !== e.inst || ipc_a[sel] !== e.pc || err_a[sel] !== e.err) begin
                    n_bad++;
                    $display("FAIL sb_strobe: got inst=%h pc=%h err=%b, required inst=%h pc=%h err=%b",
                             inst_a[sel], ipc_a[sel], err_a[sel], e.inst, e.pc, e.err);
                end
            end
        end
    end

    task automatic test_reset();
        int nv;
        sel = 1; mon_en = 1'b0; rst = 1'b0; ce = 1'b0; br = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({inst_a[1], ipc_a[1]} !== 64'h0) begin
            n_bad++; $display("FAIL reset_inst: got %h/%h, required 0/0", inst_a[1], ipc_a[1]);
        end
        n_cmp++;
        if ({valid_a[1], err_a[1], stall_a[1]} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b, required 000", {valid_a[1], err_a[1], stall_a[1]});
        end
        n_cmp++;
        if (addr_a[1] !== 20'h0) begin
            n_bad++; $display("FAIL reset_addr: got %h, required 0", addr_a[1]);
        end
        n_cmp++;
        if ({ce_n_a[1], oe_n_a[1], we_n_a[1], be_n_a[1]} !== 7'h7F) begin
            n_bad++; $display("FAIL reset_pins: got %h, required 7f", {ce_n_a[1], oe_n_a[1], we_n_a[1], be_n_a[1]});
        end
        rst = 1'b1; mon_en = 1'b1;
        @(negedge clk); ce = 1'b1; pc = BASE + 32'h40;
        @(negedge clk); ce = 1'b0;
        n_cmp++;
        if (ce_n_a[1] !== 1'b0 || stall_a[1] !== 1'b1) begin
            n_bad++; $display("FAIL reset_pre_access: got ce_n=%b stall=%b, required 0/1", ce_n_a[1], stall_a[1]);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({ce_n_a[1], oe_n_a[1], be_n_a[1], stall_a[1]} !== 7'b1111110 || addr_a[1] !== 20'h0) begin
            n_bad++; $display("FAIL reset_mid_access: got pins=%b addr=%h, required 1111110/0",
                              {ce_n_a[1], oe_n_a[1], be_n_a[1], stall_a[1]}, addr_a[1]);
        end
        @(negedge clk); rst = 1'b1;
        nv = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid_a[1]) nv++;
        end
        n_cmp++;
        if (nv != 0) begin
            n_bad++; $display("FAIL reset_no_strobe: got %0d strobes, required 0", nv);
        end
    endtask

    task automatic test_single();
        int vidx, stalls;
        sel = 1; fixed_en = 1'b1; fixed_data = 32'h2408_0001; vidx = -1; stalls = 0;
        @(negedge clk); ce = 1'b1; pc = BASE + 32'h10;
        sb.push_back('{inst: 32'h2408_0001, pc: BASE + 32'h10, err: 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ce = 1'b0;
                n_cmp++;
                if (addr_a[1] !== 20'h4 || ce_n_a[1] !== 1'b0 || oe_n_a[1] !== 1'b0 || be_n_a[1] !== 4'h0) begin
                    n_bad++; $display("FAIL single_pins: got addr=%h ce_n=%b oe_n=%b be_n=%h, required 4/0/0/0",
                                      addr_a[1], ce_n_a[1], oe_n_a[1], be_n_a[1]);
                end
            end
            if (stall_a[1]) stalls++;
            if (valid_a[1] && vidx < 0) vidx = i;
        end
        n_cmp++;
        if (stalls != 1) begin
            n_bad++; $display("FAIL single_stall: got %0d stall cycles, required 1", stalls);
        end
        n_cmp++;
        if (vidx != 2) begin
            n_bad++; $display("FAIL single_latency: got strobe at cycle %0d, required 2", vidx);
        end
        n_cmp++;
        if (inst_a[1] !== 32'h2408_0001) begin
            n_bad++; $display("FAIL single_hold: got %h, required 24080001", inst_a[1]);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL single_missing: got %0d pending, required 0", sb.size());
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] vmask;
        int         stalls;
        sel = 0; vmask = '0; stalls = 0;
        @(negedge clk); ce = 1'b1; pc = BASE; sb.push_back(exp_of(BASE));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vmask[i] = valid_a[0];
            if (stall_a[0]) stalls++;
            if (i < 3) begin
                n_cmp++;
                if (addr_a[0] !== 20'(i)) begin
                    n_bad++; $display("FAIL b2b_addr%0d: got %h, required %h", i, addr_a[0], 20'(i));
                end
            end
            if (i < 2) begin
                pc = pc + 32'h4;
                sb.push_back(exp_of(pc));
            end else begin
                ce = 1'b0;
            end
        end
        n_cmp++;
        if (vmask !== 5'b01110) begin
            n_bad++; $display("FAIL b2b_strobes: got %b, required 01110", vmask);
        end
        n_cmp++;
        if (stalls != 0) begin
            n_bad++; $display("FAIL b2b_stall: got %0d stall cycles, required 0", stalls);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL b2b_missing: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_branch();
        int nv;
        sel = 2; nv = 0;
        @(negedge clk); ce = 1'b1; pc = BASE + 32'h20;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (valid_a[2]) nv++;
            case (i)
                0: begin
                    br = 1'b1; pc = BASE + 32'h100;
                    n_cmp++;
                    if (stall_a[2] !== 1'b1) begin
                        n_bad++; $display("FAIL branch_stall_hi: got %b, required 1", stall_a[2]);
                    end
                end
                1: br = 1'b0;
                2: begin
                    n_cmp++;
                    if (stall_a[2] !== 1'b0 || ce_n_a[2] !== 1'b0) begin
                        n_bad++; $display("FAIL branch_final: got stall=%b ce_n=%b, required 0/0",
                                          stall_a[2], ce_n_a[2]);
                    end
                    sb.push_back(exp_of(pc));
                end
                3: ce = 1'b0;
                default: ;
            endcase
        end
        n_cmp++;
        if (nv != 1) begin
            n_bad++; $display("FAIL branch_count: got %0d strobes, required 1", nv);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL branch_missing: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad_pc [2];
        sel = 1;
        bad_pc[0] = BASE + 32'h2;
        bad_pc[1] = 32'h7FFF_FFFC;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if (ce_n_a[1] !== 1'b1 || valid_a[1] !== 1'b1) begin
                    n_bad++; $display("FAIL illegal%0d_resp: got ce_n=%b valid=%b, required 1/1", k - 1, ce_n_a[1], valid_a[1]);
                end
            end
            ce = 1'b1; pc = bad_pc[k];
            sb.push_back('{inst: 32'h0, pc: bad_pc[k], err: 1'b1});
        end
        @(negedge clk); ce = 1'b0;
        n_cmp++;
        if (ce_n_a[1] !== 1'b1 || valid_a[1] !== 1'b1 || err_a[1] !== 1'b1) begin
            n_bad++; $display("FAIL illegal1_resp: got ce_n=%b valid=%b err=%b, required 1/1/1",
                              ce_n_a[1], valid_a[1], err_a[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0 || valid_a[1] !== 1'b0) begin
            n_bad++; $display("FAIL illegal_tail: got pending=%0d valid=%b, required 0/0", sb.size(), valid_a[1]);
        end
    endtask

    task automatic test_window();
        sel = 1;
        @(negedge clk); ce = 1'b1; pc = BASE + 32'h003F_FFFC; sb.push_back(exp_of(pc));
        @(negedge clk); ce = 1'b0;
        n_cmp++;
        if (addr_a[1] !== 20'hFFFFF || ce_n_a[1] !== 1'b0) begin
            n_bad++; $display("FAIL window_top: got addr=%h ce_n=%b, required fffff/0", addr_a[1], ce_n_a[1]);
        end
        repeat (3) @(negedge clk);
        ce = 1'b1; pc = BASE + 32'h0040_0000;
        sb.push_back('{inst: 32'h0, pc: BASE + 32'h0040_0000, err: 1'b1});
        @(negedge clk); ce = 1'b0;
        n_cmp++;
        if (ce_n_a[1] !== 1'b1 || err_a[1] !== 1'b1) begin
            n_bad++; $display("FAIL window_over: got ce_n=%b err=%b, required 1/1", ce_n_a[1], err_a[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL window_missing: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_single();
        test_back_to_back();
        test_branch();
        test_illegal();
        test_window();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_inst_sram_rsp

`default_nettype wire
